lcd_bus_arbiter: RTL



---
 rtl/lcd_bus_arbiter.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: the only driver of the character-LCD bus.
// After reset it waits out the power-up delay and sends the fixed init sequence.
// It then round-robins single-byte writes from two valid/ready requesters.
// Each byte is shown as SETUP (data valid), PULSE (lcd_en high), then HOLD (lcd_en low).
// LCD pins and busy are registered from the state one cycle later.
// Data and rs therefore lead lcd_en by a cycle and stay put through the hold.
module lcd_bus_arbiter #(
    parameter int unsigned POWERUP_CYCLES = 1_000_000,
    parameter int unsigned EN_CYCLES      = 50_000,
    parameter int unsigned HOLD_CYCLES    = 50_000,
    parameter int unsigned CLEAR_CYCLES   = 100_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       lcd_en,
    output logic       lcd_rw,
    output logic       lcd_rs,
    output logic [7:0] lcd_data,
    output logic       init_done,
    output logic       busy
);

    localparam logic [31:0] PWR_LAST = 32'(POWERUP_CYCLES - 1);
    localparam logic [31:0] EN_LAST  = 32'(EN_CYCLES - 1);
    localparam logic [31:0] HLD_LAST = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] CLR_LAST = 32'(CLEAR_CYCLES - 1);

    typedef enum logic [2:0] {
        StPwrup,
        StSetup,
        StPulse,
        StHold,
        StArb
    } state_e;

    state_e      state;
    logic [31:0] cnt;
    logic [2:0]  init_idx;
    logic        last_grant;   // 1: port 1 was granted most recently
    logic        byte_rs;
    logic [7:0]  byte_data;
    logic [31:0] hold_last;

    // Fixed power-up command sequence.
    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h38;
            3'd1:    b = 8'h0E;
            3'd2:    b = 8'h01;
            3'd3:    b = 8'h02;
            default: b = 8'h06;
        endcase
        return b;
    endfunction

    // Clear and home commands need the longer post-write wait.
    always_comb begin
        hold_last = HLD_LAST;
        if (!byte_rs && (byte_data == 8'h01 || byte_data == 8'h02)) begin
            hold_last = CLR_LAST;
        end
    end

    // Round-robin grant; a ready only ever appears alongside its own valid.
    assign req0_ready = (state == StArb) && init_done && req0_valid
                        && (!req1_valid || last_grant);
    assign req1_ready = (state == StArb) && init_done && req1_valid
                        && (!req0_valid || !last_grant);

    // The display is only ever written.
    assign lcd_rw = 1'b0;

    // Sequencer: init, per-byte pulse/hold timing, and acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StPwrup;
            cnt        <= '0;
            init_idx   <= '0;
            last_grant <= 1'b1;
            byte_rs    <= 1'b0;
            byte_data  <= 8'h00;
            lcd_en     <= 1'b0;
            lcd_rs     <= 1'b0;
            lcd_data   <= 8'h00;
            init_done  <= 1'b0;
            busy       <= 1'b1;
        end else begin
            lcd_en <= (state == StPulse);
            busy   <= !((state == StArb) && init_done);
            unique case (state)
                StPwrup: begin
                    if (cnt == PWR_LAST) begin
                        cnt       <= '0;
                        byte_rs   <= 1'b0;
                        byte_data <= init_byte(3'd0);
                        state     <= StSetup;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                StSetup: begin
                    lcd_rs   <= byte_rs;
                    lcd_data <= byte_data;
                    cnt      <= '0;
                    state    <= StPulse;
                end
                StPulse: begin
                    if (cnt == EN_LAST) begin
                        cnt   <= '0;
                        state <= StHold;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                StHold: begin
                    if (cnt == hold_last) begin
                        cnt <= '0;
                        if (!init_done && init_idx < 3'd4) begin
                            init_idx  <= init_idx + 3'd1;
                            byte_rs   <= 1'b0;
                            byte_data <= init_byte(init_idx + 3'd1);
                            state     <= StSetup;
                        end else begin
                            // Sticky: re-asserting after requester bytes is harmless.
                            init_done <= 1'b1;
                            state     <= StArb;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                StArb: begin
                    if (req0_ready) begin
                        byte_rs    <= req0_rs;
                        byte_data  <= req0_data;
                        last_grant <= 1'b0;
                        state      <= StSetup;
                    end else if (req1_ready) begin
                        byte_rs    <= req1_rs;
                        byte_data  <= req1_data;
                        last_grant <= 1'b1;
                        state      <= StSetup;
                    end
                end
                default: state <= StPwrup;
            endcase
        end
    end

endmodule
